// File: rtl/ram_serializer.sv
// Reads a block from RAM and shifts it out MSB first as packets of
// HEADER followed by up to BYTES_PER_PKT payload bytes, with idle gaps between bytes.
module ram_serializer #(
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         BYTES_PER_PKT = 4,
    parameter int         GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] base_addr,
    input  logic [10:0] length,
    input  logic [7:0]  ram_data,
    output logic [10:0] ram_addr,
    output logic        ram_rd_n,
    output logic        serial_data,
    output logic        data_ena,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [10:0]   base, idx, remaining;
    logic [3:0]    pkt_cnt;
    logic          cur_payload, next_payload;
    logic [7:0]    load_byte;

    // With a two-cycle gap the RAM byte arrives on the same edge that starts shifting it.
    always_comb begin
        load_byte = shreg;
        if (next_payload && gap_cnt == GW'(1))
            load_byte = ram_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            base         <= '0;
            idx          <= '0;
            remaining    <= '0;
            pkt_cnt      <= '0;
            cur_payload  <= 1'b0;
            next_payload <= 1'b0;
            ram_addr     <= '0;
            ram_rd_n     <= 1'b1;
            serial_data  <= 1'b0;
            data_ena     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base        <= base_addr;
                        remaining   <= length;
                        idx         <= '0;
                        pkt_cnt     <= '0;
                        busy        <= 1'b1;
                        cur_payload <= 1'b0;
                        if (length == 11'd0) begin
                            state <= DONE;
                        end else begin
                            state       <= SHIFT;
                            shreg       <= HEADER;
                            serial_data <= HEADER[7];
                            data_ena    <= 1'b1;
                            bit_cnt     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt != 3'd7) begin
                        shreg       <= {shreg[6:0], 1'b0};
                        serial_data <= shreg[6];
                        bit_cnt     <= bit_cnt + 3'd1;
                    end else begin
                        data_ena    <= 1'b0;
                        serial_data <= 1'b0;
                        gap_cnt     <= '0;
                        if (cur_payload && remaining == 11'd1) begin
                            remaining <= '0;
                            state     <= DONE;
                            done      <= 1'b1;
                        end else begin
                            if (cur_payload)
                                remaining <= remaining - 11'd1;
                            state <= GAP;
                            // After a header a payload byte is always due; after a payload
                            // byte only if the packet is not yet full.
                            if (!cur_payload || pkt_cnt != 4'(BYTES_PER_PKT)) begin
                                ram_rd_n     <= 1'b0;
                                ram_addr     <= base + idx;
                                idx          <= idx + 11'd1;
                                next_payload <= 1'b1;
                            end else begin
                                shreg        <= HEADER;
                                next_payload <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    ram_rd_n <= 1'b1;
                    if (next_payload && gap_cnt == GW'(1))
                        shreg <= ram_data;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state       <= SHIFT;
                        shreg       <= load_byte;
                        serial_data <= load_byte[7];
                        data_ena    <= 1'b1;
                        bit_cnt     <= '0;
                        cur_payload <= next_payload;
                        pkt_cnt     <= next_payload ? pkt_cnt + 4'd1 : 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    // An empty block arrives here without done set and pulses it now.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_serializer.sv
// Scoreboard bench for ram_serializer: expected bytes, read addresses and done
// latency are queued at start and checked by an independent monitor.
module tb_ram_serializer;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int BPP = 4;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [10:0] base_addr, length;
    logic [7:0]  ram_data = 8'h00;
    logic [10:0] ram_addr;
    logic        ram_rd_n, serial_data, data_ena, busy, done;

    ram_serializer #(.HEADER(HDR), .BYTES_PER_PKT(BPP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_rd_n(ram_rd_n), .serial_data(serial_data), .data_ena(data_ena),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];
    always @(posedge clk) if (!ram_rd_n) ram_data <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_bytes[$];
    logic [10:0] exp_addr[$];
    int          exp_t0[$], exp_lat[$];
    int vectors = 0, errs = 0, done_cnt = 0, bits_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        errs++;
        $display("FAIL %s: DUT produced output with nothing expected (cycle %0d)", name, cyc);
    endtask

    function automatic int exp_latency(input int l);
        int nb;
        if (l == 0) return 2;
        nb = l + (l + BPP - 1) / BPP;
        return 8 * nb + GAP * (nb - 1) + 1;
    endfunction

    // Monitor: assembles bytes from the serial stream and retires expectations.
    initial begin
        logic [7:0] acc;
        int nbits;
        acc = '0;
        nbits = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_bytes.delete();
                exp_addr.delete();
                exp_t0.delete();
                exp_lat.delete();
                nbits = 0;
            end else begin
                if (data_ena) begin
                    acc = {acc[6:0], serial_data};
                    nbits++;
                    bits_seen++;
                    if (nbits == 8) begin
                        nbits = 0;
                        if (exp_bytes.size() == 0) unexpected("byte");
                        else chk("byte", acc, exp_bytes.pop_front());
                    end
                end
                if (!ram_rd_n) begin
                    if (exp_addr.size() == 0) unexpected("rd_addr");
                    else chk("rd_addr", ram_addr, exp_addr.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    if (exp_lat.size() == 0) unexpected("done");
                    else begin
                        chk("latency", cyc - exp_t0.pop_front(), exp_lat.pop_front());
                        chk("bytes_left", exp_bytes.size(), 0);
                        chk("reads_left", exp_addr.size(), 0);
                        chk("partial_bits", nbits, 0);
                    end
                end
            end
        end
    end

    task automatic reset_check(input string tag);
        chk({tag, "_rd_n"}, ram_rd_n, 1);
        chk({tag, "_data_ena"}, data_ena, 0);
        chk({tag, "_serial"}, serial_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, ram_addr, 0);
    endtask

    task automatic start_block(input logic [10:0] b, input logic [10:0] l);
        logic [10:0] a;
        @(posedge clk); #1;
        if (l != 0) exp_bytes.push_back(HDR);
        for (int i = 0; i < int'(l); i++) begin
            if (i > 0 && i % BPP == 0) exp_bytes.push_back(HDR);
            a = b + 11'(i);
            exp_addr.push_back(a);
            exp_bytes.push_back(mem[a]);
        end
        exp_t0.push_back(cyc);
        exp_lat.push_back(exp_latency(int'(l)));
        base_addr = b;
        length = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(posedge clk); #1; n++; end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin @(posedge clk); #1; n++; end
        if (done_cnt == d0) chk("done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic run_block(input logic [10:0] b, input logic [10:0] l);
        int d0;
        wait_idle();
        d0 = done_cnt;
        start_block(b, l);
        wait_done(d0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, b0, n;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_check("reset");

        run_block(11'h010, 11'd4);
        run_block(11'h100, 11'd6);
        run_block(11'h020, 11'd0);
        run_block(11'h7FE, 11'd3);

        // A second start in the middle of a block must not disturb it.
        wait_idle();
        d0 = done_cnt;
        start_block(11'h300, 11'd5);
        repeat (20) @(posedge clk);
        #1 base_addr = 11'h555; length = 11'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d0);
        repeat (10) @(posedge clk);
        #1 chk("done_once_ignored_start", done_cnt - d0, 1);

        // Reset during the third bit of the third byte of the stream.
        wait_idle();
        d0 = done_cnt;
        start_block(11'h400, 11'd8);
        b0 = bits_seen;
        n = 0;
        while (bits_seen < b0 + 18 && n < 500) begin @(negedge clk); #1; n++; end
        chk("reached_reset_point", bits_seen - b0, 18);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        reset_check("abort");
        repeat (80) @(posedge clk);
        #1 chk("no_done_after_abort", done_cnt, d0);
        run_block(11'h400, 11'd8);

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; base_addr = 11'h010; length = 11'd4;
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_over_start_busy", busy, 0);
        chk("reset_over_start_ena", data_ena, 0);

        repeat (10) run_block(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 20)));

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/ram_serializer.md
RAM_SERIALIZER -- requirements
Module: ram_serializer

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, header byte sent before each packet.
REQ-002 SHALL have parameter BYTES_PER_PKT, default 4, number of payload bytes per packet (range 1..15).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, number of idle cycles between bytes (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to transmit one block.
REQ-007 SHALL have port base_addr, input, 11 bits: first RAM address of the block.
REQ-008 SHALL have port length, input, 11 bits: payload byte count.
REQ-009 SHALL have port ram_data, input, 8 bits: RAM read data, valid one cycle after ram_rd_n is low.
REQ-010 SHALL have port ram_addr, output, 11 bits: RAM read address.
REQ-011 SHALL have port ram_rd_n, output, 1 bit: active-low read strobe.
REQ-012 SHALL have port serial_data, output, 1 bit: serial bit stream.
REQ-013 SHALL have port data_ena, output, 1 bit: high while serial_data carries a valid bit.
REQ-014 SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at block completion.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, GAP, DONE; every output SHALL be registered.
REQ-017 In IDLE, start=1 SHALL latch base_addr and length, assert busy, and enter SHIFT on the next cycle with the shift register loaded with HEADER; if length=0, it SHALL enter DONE instead.
REQ-018 SHIFT SHALL last exactly 8 cycles, with data_ena=1 and serial_data=shreg[7] (MSB first), shifting left once per cycle.
REQ-019 After the 8th bit, the FSM SHALL enter GAP for GAP_CYCLES cycles with data_ena=0 and serial_data=0.
REQ-020 If a payload byte is due next, the first GAP cycle SHALL drive ram_rd_n=0 with ram_addr=(base+index) mod 2048; the second GAP cycle SHALL capture ram_data into the shift register.
REQ-021 ram_rd_n SHALL be low for exactly one cycle per payload byte and high at all other times.
REQ-022 Byte sequence per packet: HEADER, then up to BYTES_PER_PKT payload bytes; after BYTES_PER_PKT payload bytes, if bytes remain, the next byte SHALL be HEADER.
REQ-023 The last packet MAY be short; when the remaining count reaches 0 after a payload byte's 8th bit, the FSM SHALL enter DONE directly, with no trailing gap.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0 on the following cycle; the FSM SHALL then return to IDLE.
REQ-025 start SHALL be ignored while busy=1 or in DONE.
REQ-026 The address index SHALL be 11 bits and wrap from 2047 to 0.
REQ-027 ram_addr SHALL hold its last value when ram_rd_n=1.

Reset
REQ-028 With reset=1 at a clock edge, the next state SHALL be IDLE, with ram_rd_n=1, data_ena=0, serial_data=0, busy=0, done=0, ram_addr=0, and all counters cleared.
REQ-029 Reset mid-transfer SHALL abort immediately with no done pulse; a subsequent start SHALL begin a fresh block.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 With base=0x010, length=4, and RAM[0x10..0x13]=11,22,33,44 -> the stream SHALL be A5,11,22,33,44 MSB first; there SHALL be 8 data_ena-high cycles per byte and 2-cycle gaps; done SHALL pulse once; the total from start to done SHALL be 49 cycles.
REQ-032 With length=6 -> the stream SHALL be A5,d0,d1,d2,d3,A5,d4,d5, with exactly 6 ram_rd_n pulses.
REQ-033 With length=0 -> there SHALL be no data_ena, no ram_rd_n, and done SHALL occur 2 cycles after start.
REQ-034 With base=0x7FE and length=3 -> the read addresses SHALL be 0x7FE, 0x7FF, 0x000.
REQ-035 A start pulse during an active block -> SHALL be ignored; the stream SHALL be unchanged and done SHALL pulse exactly once.
REQ-036 Reset asserted in the 3rd bit of payload byte 2 -> outputs SHALL reach reset values on the next cycle with no done; a new start SHALL produce a correct full stream.
